// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types, block geometry and byte-swap helper for the SHA-256 message sequencer
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_LEN,
        ST_FIRE,
        ST_WAIT0,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam int         WORDS_PER_BLK = 16;
    localparam logic [3:0] LEN_HI_IDX    = 4'd14;
    localparam logic [3:0] LEN_LO_IDX    = 4'd15;
    localparam logic [7:0] PAD_BYTE      = 8'h80;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_last_word_pad.sv
// rtl/sha256_last_word_pad.sv - masks the final message word and inserts the 0x80 pad byte after the last valid byte
module sha256_last_word_pad
    import sha256_pkg::*;
(
    input  logic [31:0] tdata,
    input  logic [2:0]  tbytes,
    output logic [31:0] pad_word,
    output logic [2:0]  nbytes,
    output logic        full
);

    always_comb begin
        full     = (tbytes >= 3'd4);
        nbytes   = full ? 3'd4 : tbytes;
        pad_word = tdata;
        // A full word passes through untouched; its pad byte goes into the next word.
        if (!full) begin
            for (int b = 0; b < 4; b++) begin
                if (b == int'(tbytes)) begin
                    pad_word[b*8 +: 8] = PAD_BYTE;
                end else if (b > int'(tbytes)) begin
                    pad_word[b*8 +: 8] = 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// rtl/sha256_msg_sequencer.sv - streams message words into the SHA-256 block buffer, pads, appends length and sequences the core
module sha256_msg_sequencer
    import sha256_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_tdata,
    input  logic [2:0]  s_tbytes,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        blk_we,
    output logic [3:0]  blk_idx,
    output logic [31:0] blk_wdata,
    output logic        core_start,
    output logic        core_init,
    input  logic        core_busy,
    output logic        msg_done,
    output logic        seq_busy
);

    state_e           state_q, state_d;
    logic [4:0]       widx_q, widx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             final_q, final_d;
    logic             pend_q, pend_d;
    logic             padded_q, padded_d;
    logic             extra_q, extra_d;
    logic             en_q, en_d;

    logic [31:0] pad_word;
    logic [2:0]  last_nbytes;
    logic        last_full;
    logic [63:0] bitlen;
    logic [4:0]  widx_inc;

    sha256_last_word_pad u_pad (
        .tdata    (s_tdata),
        .tbytes   (s_tbytes),
        .pad_word (pad_word),
        .nbytes   (last_nbytes),
        .full     (last_full)
    );

    assign bitlen   = 64'({cnt_q, 3'b000});
    assign widx_inc = widx_q + 5'd1;

    // long_pad: the pad byte landed in word 14 or 15, so the length needs a block of its own.
    function automatic state_e after_pad(input logic [4:0] nidx, input logic long_pad);
        if (long_pad) begin
            return (nidx == 5'(WORDS_PER_BLK)) ? ST_FIRE : ST_PAD;
        end
        return (nidx == 5'(LEN_HI_IDX)) ? ST_LEN : ST_PAD;
    endfunction

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        final_d    = final_q;
        pend_d     = pend_q;
        padded_d   = padded_q;
        extra_d    = extra_q;
        en_d       = 1'b1;
        s_tready   = 1'b0;
        blk_we     = 1'b0;
        blk_idx    = widx_q[3:0];
        blk_wdata  = 32'h0;
        core_start = 1'b0;
        core_init  = 1'b0;
        msg_done   = 1'b0;
        seq_busy   = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                s_tready = en_q & !core_busy & (widx_q < 5'(WORDS_PER_BLK));
                if (s_tvalid && s_tready) begin
                    if (state_q == ST_IDLE) begin
                        first_d = 1'b1;
                    end
                    blk_we = 1'b1;
                    widx_d = widx_inc;
                    if (!s_tlast) begin
                        blk_wdata = s_tdata;
                        cnt_d     = cnt_q + CNT_W'(4);
                        state_d   = (widx_q == 5'd15) ? ST_FIRE : ST_LOAD;
                    end else begin
                        blk_wdata = pad_word;
                        cnt_d     = cnt_q + CNT_W'(last_nbytes);
                        if (last_full) begin
                            pend_d  = 1'b1;
                            state_d = (widx_q == 5'd15) ? ST_FIRE : ST_PAD;
                        end else begin
                            padded_d = 1'b1;
                            extra_d  = (widx_q >= 5'(LEN_HI_IDX));
                            state_d  = after_pad(widx_inc, widx_q >= 5'(LEN_HI_IDX));
                        end
                    end
                end
            end
            ST_PAD: begin
                if (!core_busy) begin
                    blk_we = 1'b1;
                    widx_d = widx_inc;
                    if (pend_q) begin
                        blk_wdata = 32'(PAD_BYTE);
                        pend_d    = 1'b0;
                        padded_d  = 1'b1;
                        extra_d   = (widx_q >= 5'(LEN_HI_IDX));
                        state_d   = after_pad(widx_inc, widx_q >= 5'(LEN_HI_IDX));
                    end else begin
                        state_d = after_pad(widx_inc, extra_q);
                    end
                end
            end
            ST_LEN: begin
                if (!core_busy) begin
                    blk_we = 1'b1;
                    widx_d = widx_inc;
                    if (widx_q[3:0] == LEN_LO_IDX) begin
                        blk_wdata = bswap32(bitlen[31:0]);
                        final_d   = 1'b1;
                        state_d   = ST_FIRE;
                    end else begin
                        blk_wdata = bswap32(bitlen[63:32]);
                    end
                end
            end
            ST_FIRE: begin
                core_start = 1'b1;
                core_init  = first_q;
                first_d    = 1'b0;
                widx_d     = 5'd0;
                extra_d    = 1'b0;
                state_d    = ST_WAIT0;
            end
            ST_WAIT0: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!core_busy) begin
                    if (final_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = (padded_q || pend_q) ? ST_PAD : ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                msg_done = 1'b1;
                state_d  = ST_IDLE;
                widx_d   = 5'd0;
                cnt_d    = '0;
                final_d  = 1'b0;
                pend_d   = 1'b0;
                padded_d = 1'b0;
                extra_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            widx_q   <= 5'd0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            final_q  <= 1'b0;
            pend_q   <= 1'b0;
            padded_q <= 1'b0;
            extra_q  <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            final_q  <= final_d;
            pend_q   <= pend_d;
            padded_q <= padded_d;
            extra_q  <= extra_d;
            en_q     <= en_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// tb/tb_sha256_msg_sequencer.sv - self-checking bench for the SHA-256 message sequencer
module tb_sha256_msg_sequencer;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic [2:0]  s_tbytes;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic        blk_we;
    logic [3:0]  blk_idx;
    logic [31:0] blk_wdata;
    logic        core_start;
    logic        core_init;
    logic        core_busy;
    logic        msg_done;
    logic        seq_busy;

    sha256_msg_sequencer #(.CNT_W(32)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tdata    (s_tdata),
        .s_tbytes   (s_tbytes),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .blk_we     (blk_we),
        .blk_idx    (blk_idx),
        .blk_wdata  (blk_wdata),
        .core_start (core_start),
        .core_init  (core_init),
        .core_busy  (core_busy),
        .msg_done   (msg_done),
        .seq_busy   (seq_busy)
    );

    typedef struct packed {
        logic             init;
        logic [7:0]       nwr;
        logic [15:0][31:0] w;
    } blk_t;

    typedef struct {
        logic [31:0] tdata;
        logic [2:0]  tbytes;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w15;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;
    int busy_len = 3;

    blk_t              blocks[$];
    logic [15:0][31:0] mem;
    logic [7:0]        wr_cnt;
    int                done_cnt = 0;
    int                done_at_blocks = 0;
    int                busy_viol = 0;
    int                stall_cyc = 0;
    int                cyc = 0;
    int                last_cyc = 0;
    int                start_lat = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Block-buffer and handshake monitor; every completed block is snapshotted at core_start.
    initial begin
        mem    = {16{32'hDEADBEEF}};
        wr_cnt = 8'd0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn) begin
                wr_cnt = 8'd0;
                mem    = {16{32'hDEADBEEF}};
            end else begin
                if (core_busy && (s_tready || blk_we)) busy_viol++;
                if (core_busy && s_tvalid) stall_cyc++;
                if (s_tvalid && s_tready && s_tlast) last_cyc = cyc;
                if (blk_we) begin
                    mem[blk_idx] = blk_wdata;
                    wr_cnt++;
                end
                if (core_start) begin
                    blocks.push_back('{init: core_init, nwr: wr_cnt, w: mem});
                    start_lat = cyc - last_cyc;
                    wr_cnt    = 8'd0;
                    mem       = {16{32'hDEADBEEF}};
                end
                if (msg_done) begin
                    done_cnt++;
                    done_at_blocks = blocks.size();
                end
            end
        end
    end

    // Compression core stand-in: busy rises the cycle after start and holds for busy_len cycles.
    initial begin
        core_busy = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn && core_start) begin
                @(posedge aclk);
                #1 core_busy = 1'b1;
                repeat (busy_len) @(posedge aclk);
                #1 core_busy = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic fail_note(input string nm);
        total_cnt++;
        $display("FAIL %s: bounded wait expired", nm);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t;
        t        = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tbytes = nb;
        s_tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_tready) break;
            t++;
            if (t > 200) begin
                fail_note("tready_timeout");
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_words(input int n, input logic [31:0] base, input logic [2:0] lastb);
        for (int k = 0; k < n; k++) begin
            send_beat(base + 32'(k), (k == n - 1), (k == n - 1) ? lastb : 3'd4);
        end
    endtask

    task automatic wait_done(input string nm, input int prev);
        int t;
        t = 0;
        while (done_cnt == prev && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        if (done_cnt == prev) fail_note({nm, "_done_timeout"});
        @(posedge aclk);
        #1;
    endtask

    task automatic check_block(input string nm, input int bi, input logic init,
                               input logic [15:0][31:0] ew);
        if (bi >= blocks.size()) begin
            fail_note({nm, "_missing"});
            return;
        end
        check({nm, "_init"}, 32'(blocks[bi].init), 32'(init));
        check({nm, "_nwr"}, 32'(blocks[bi].nwr), 32'd16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_w%0d", nm, k), blocks[bi].w[k], ew[k]);
        end
    endtask

    task automatic run_hello(input string nm);
        int nb;
        int nd;
        logic [15:0][31:0] ew;
        nb = blocks.size();
        nd = done_cnt;
        send_beat(32'h6c6c6568, 1'b0, 3'd4);
        send_beat(32'h6f77206f, 1'b0, 3'd4);
        send_beat(32'h00646c72, 1'b1, 3'd3);
        wait_done(nm, nd);
        ew     = '0;
        ew[0]  = 32'h6c6c6568;
        ew[1]  = 32'h6f77206f;
        ew[2]  = 32'h80646c72;
        ew[15] = 32'h58000000;
        check({nm, "_nblk"}, 32'(blocks.size() - nb), 32'd1);
        check({nm, "_latency"}, 32'(start_lat), 32'd14);
        check_block({nm, "_b0"}, nb, 1'b1, ew);
    endtask

    vec_t              vecs[7];
    logic [15:0][31:0] ew;
    logic [15:0][31:0] ew2;
    int                nb;
    int                nd;
    int                st0;

    initial begin
        vecs[0] = '{32'h44332211, 3'd0, 32'h00000080, 32'h0,         32'h00000000};
        vecs[1] = '{32'h44332211, 3'd1, 32'h00008011, 32'h0,         32'h08000000};
        vecs[2] = '{32'h44332211, 3'd2, 32'h00802211, 32'h0,         32'h10000000};
        vecs[3] = '{32'h44332211, 3'd3, 32'h80332211, 32'h0,         32'h18000000};
        vecs[4] = '{32'h44332211, 3'd4, 32'h44332211, 32'h00000080, 32'h20000000};
        vecs[5] = '{32'h44332211, 3'd7, 32'h44332211, 32'h00000080, 32'h20000000};
        vecs[6] = '{32'hFFFFFFFF, 3'd2, 32'h0080FFFF, 32'h0,         32'h10000000};

        aresetn  = 1'b0;
        s_tdata  = 32'h0;
        s_tbytes = 3'd0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tready", 32'(s_tready), 32'd0);
        check("rst_blk_we", 32'(blk_we), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_msg_done", 32'(msg_done), 32'd0);
        check("rst_seq_busy", 32'(seq_busy), 32'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        for (int i = 0; i < 7; i++) begin
            nb = blocks.size();
            nd = done_cnt;
            send_beat(vecs[i].tdata, 1'b1, vecs[i].tbytes);
            wait_done($sformatf("vec%0d", i), nd);
            ew     = '0;
            ew[0]  = vecs[i].w0;
            ew[1]  = vecs[i].w1;
            ew[15] = vecs[i].w15;
            check($sformatf("vec%0d_nblk", i), 32'(blocks.size() - nb), 32'd1);
            check_block($sformatf("vec%0d", i), nb, 1'b1, ew);
        end

        run_hello("hello");

        // 56 bytes: pad byte lands in word 14, length spills into a second block
        nb = blocks.size();
        nd = done_cnt;
        send_words(14, 32'h10000000, 3'd4);
        wait_done("m56", nd);
        ew  = '0;
        ew2 = '0;
        for (int k = 0; k < 14; k++) ew[k] = 32'h10000000 + 32'(k);
        ew[14]  = 32'h00000080;
        ew2[15] = 32'hC0010000;
        check("m56_nblk", 32'(blocks.size() - nb), 32'd2);
        check("m56_done_after_b2", 32'(done_at_blocks - nb), 32'd2);
        check_block("m56_b0", nb, 1'b1, ew);
        check_block("m56_b1", nb + 1, 1'b0, ew2);

        // 64 bytes: data-only block then a pad/length block
        nb = blocks.size();
        nd = done_cnt;
        send_words(16, 32'h20000000, 3'd4);
        wait_done("m64", nd);
        ew  = '0;
        ew2 = '0;
        for (int k = 0; k < 16; k++) ew[k] = 32'h20000000 + 32'(k);
        ew2[0]  = 32'h00000080;
        ew2[15] = 32'h00020000;
        check("m64_nblk", 32'(blocks.size() - nb), 32'd2);
        check_block("m64_b0", nb, 1'b1, ew);
        check_block("m64_b1", nb + 1, 1'b0, ew2);

        // 68 bytes with a long core busy while beat 16 is being offered
        busy_len = 20;
        st0      = stall_cyc;
        nb       = blocks.size();
        nd       = done_cnt;
        send_words(17, 32'h30000000, 3'd4);
        wait_done("bp", nd);
        busy_len = 3;
        ew  = '0;
        ew2 = '0;
        for (int k = 0; k < 16; k++) ew[k] = 32'h30000000 + 32'(k);
        ew2[0]  = 32'h30000010;
        ew2[1]  = 32'h00000080;
        ew2[15] = 32'h20020000;
        check("bp_nblk", 32'(blocks.size() - nb), 32'd2);
        check("bp_stalled", 32'((stall_cyc - st0) >= 18), 32'd1);
        check_block("bp_b0", nb, 1'b1, ew);
        check_block("bp_b1", nb + 1, 1'b0, ew2);

        // Reset in the middle of LOAD with a beat still offered
        nb = blocks.size();
        send_beat(32'h11111111, 1'b0, 3'd4);
        send_beat(32'h22222222, 1'b0, 3'd4);
        s_tdata  = 32'h33333333;
        s_tbytes = 3'd4;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        @(negedge aclk);
        check("mid_seq_busy", 32'(seq_busy), 32'd1);
        check("mid_tready", 32'(s_tready), 32'd1);
        aresetn = 1'b0;
        #1;
        check("arst_tready", 32'(s_tready), 32'd0);
        check("arst_blk_we", 32'(blk_we), 32'd0);
        check("arst_core_start", 32'(core_start), 32'd0);
        check("arst_seq_busy", 32'(seq_busy), 32'd0);
        check("arst_msg_done", 32'(msg_done), 32'd0);
        s_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (30) @(posedge aclk);
        #1;
        check("arst_no_start", 32'(blocks.size() - nb), 32'd0);
        run_hello("hello2");

        check("no_activity_while_busy", 32'(busy_viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Front-end controller for the SHA-256 compression core. It accepts a message as a 32-bit little-endian word stream, writes each 512-bit block into the core's 16-word block buffer, and appends the FIPS 180-4 padding and 64-bit bit-length. It issues start/init to the core for every block and waits for the core's busy flag to clear between blocks. It sits between a DMA/stream source and the core, replacing software word-by-word programming of the core's block registers.

Parameters:
CNT_W, 32, width of the internal message byte counter; the bit length is {zero-extend, cnt, 3'b000} to 64 bits.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous assert, active-low
s_tdata  in  32  message word; byte 0 in [7:0]
s_tbytes  in  3  valid bytes in the last beat, 0..4; ignored on non-last beats, which are always 4
s_tlast  in  1  final beat of the message
s_tvalid  in  1  beat valid
s_tready  out  1  beat accepted when s_tvalid & s_tready
blk_we  out  1  write strobe to the core block buffer
blk_idx  out  4  word index 0..15
blk_wdata  out  32  word data, same byte order as s_tdata
core_start  out  1  one-cycle pulse: compress the current block
core_init  out  1  valid with core_start; 1 = first block, reload IV
core_busy  in  1  core compressing; asserts the cycle after core_start
msg_done  out  1  one-cycle pulse after the final block completes
seq_busy  out  1  high from the first accepted beat until msg_done

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset asserted mid-message aborts the message; no start is issued after release.
- States: IDLE, LOAD, PAD, LEN, FIRE, WAIT0, WAIT, DONE.
- IDLE: s_tready=1 only if core_busy=0. The first beat moves to LOAD handling in the same cycle. first_blk is set to 1.
- LOAD:
  - s_tready = !core_busy & (widx<16). Each accepted beat drives blk_we=1, blk_idx=widx, blk_wdata=s_tdata, then increments widx and adds 4 to cnt.
  - A last beat adds s_tbytes instead of 4; values >4 are clamped to 4.
  - Last beat with 0..3 bytes: bytes at and above the count are zeroed, and 0x80 is placed in byte position s_tbytes of the same word. pad_done is set.
  - Last beat with 4 bytes: the word is written unchanged; 0x80 is pending for the next word.
  - When widx reaches 16 without last: go to FIRE.
- PAD: one word per cycle.
  - If 0x80 is pending, write word 0x00000080 first.
  - Then write zero words until widx==14.
  - If 0x80 was written at or after word 14 (message byte position mod 64 ≥ 56): zero-fill to 16, FIRE, and after WAIT return to PAD with widx=0.
- LEN:
  - word14 = bswap(bitlen[63:32]); word15 = bswap(bitlen[31:0]). Example: 88 bits gives word15=0x58000000.
  - Then FIRE with a final flag.
- FIRE: core_start=1 for one cycle, core_init=first_blk. Clear first_blk and widx.
- WAIT0: one cycle, core_busy ignored.
- WAIT: hold while core_busy=1. On 0, go to DONE if final, else back to LOAD or PAD.
- DONE: msg_done=1 for one cycle, then IDLE.
- Throughput: one word per cycle. Latency from the last data beat to core_start is (words of padding remaining) + 1.
- No beat is accepted and no blk_we is issued while core_busy=1.
- The counter wraps modulo 2^CNT_W.

Decomposition:
- Package sha256_pkg holds: the FSM state enum, WORDS_PER_BLK=16, LEN_HI_IDX=14, LEN_LO_IDX=15, PAD_BYTE=8'h80, and a bswap32 function.
- One natural sub-module: sha256_last_word_pad. Combinational masking of the last word plus 0x80 insertion from s_tbytes.

Test Plan:
1. "hello world" (3 beats: 0x6c6c6568, 0x6f77206f, last 0x00646c72 with bytes=3):
   - words 0..2 = 0x6c6c6568, 0x6f77206f, 0x80646c72; words 3..14 = 0; word15=0x58000000.
   - One core_start with core_init=1; msg_done after busy falls.
   - With the real core, digest b94d27b9...cde9.
2. Empty message (single last beat, bytes=0): word0=0x00000080, words 1..15 = 0, one start with init=1.
3. 56-byte message (last beat bytes=4):
   - Block 1: word14=0x00000080, word15=0, init=1.
   - Block 2: all zero except word15=0xC0010000, init=0.
   - msg_done only after the second busy falls.
4. 64-byte message:
   - Block 1: data only.
   - Block 2: word0=0x00000080, word15=0x00020000.
   - Exactly two core_start pulses.
5. Backpressure: hold core_busy=1 for 20 cycles during a multi-block message. s_tready=0 and blk_we=0 throughout; there is no lost or duplicated word.
6. aresetn pulsed low mid-LOAD: all outputs 0 at once. After release, a new "hello world" produces case 1 exactly, with init=1.
